// File: rtl/raptor64_opfetch_if.sv
// Bundle of every signal the operand-fetch stage exchanges with the rest of the
// pipeline: upstream issue, register-file read, bypass, control and downstream.
interface raptor64_opfetch_if;
  // upstream
  logic [41:0] rIR;
  logic        rvalid;
  logic        rstall;
  // register file
  logic [4:0]  rfRa;
  logic [4:0]  rfRb;
  logic [63:0] rfoa;
  logic [63:0] rfob;
  // bypass sources
  logic [4:0]  xRt;
  logic [63:0] xres;
  logic        xwr;
  logic [4:0]  mRt;
  logic [63:0] mres;
  logic        mwr;
  logic [4:0]  wRt;
  logic [63:0] wres;
  logic        wwr;
  logic        xLoad;
  // control
  logic        xstall;
  logic        flush;
  // downstream
  logic [41:0] xIR;
  logic        xvalid;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] imm;
  logic [31:0] ilock_cnt;

  // master: the surrounding pipeline; slave: the operand-fetch stage
  modport master (
    output rIR, rvalid, rfoa, rfob,
           xRt, xres, xwr, mRt, mres, mwr, wRt, wres, wwr, xLoad,
           xstall, flush,
    input  rstall, rfRa, rfRb, xIR, xvalid, a, b, imm, ilock_cnt
  );

  modport slave (
    input  rIR, rvalid, rfoa, rfob,
           xRt, xres, xwr, mRt, mres, mwr, wRt, wres, wwr, xLoad,
           xstall, flush,
    output rstall, rfRa, rfRb, xIR, xvalid, a, b, imm, ilock_cnt
  );
endinterface

// File: rtl/raptor64_opfetch.sv
// Raptor64 operand-fetch stage: register read, x/m/w bypass, immediate sign
// extension and a one-bubble load-use interlock feeding the execute stage.
module raptor64_opfetch (
  input  logic clk_i,
  input  logic rst_i,
  raptor64_opfetch_if.slave bus
);

  localparam logic [6:0] OP_RR = 7'd2;

  logic [6:0]  opcode;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        is_rr;
  logic        hazard;
  logic [63:0] a_sel;
  logic [63:0] b_sel;
  logic [63:0] imm_sel;

  logic [41:0] x_ir;
  logic        x_valid;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] imm_q;
  logic [31:0] ilock_cnt_q;

  assign opcode = bus.rIR[41:35];
  assign ra     = bus.rIR[34:30];
  assign rb     = bus.rIR[29:25];
  assign is_rr  = (opcode == OP_RR);

  assign bus.rfRa = ra;
  assign bus.rfRb = rb;

  // Youngest writer wins; R0 always reads as zero regardless of any bypass.
  function automatic logic [63:0] forward(
    input logic [4:0]  r,
    input logic [63:0] rf_data,
    input logic [4:0]  x_rt, input logic [63:0] x_res, input logic x_wr,
    input logic [4:0]  m_rt, input logic [63:0] m_res, input logic m_wr,
    input logic [4:0]  w_rt, input logic [63:0] w_res, input logic w_wr
  );
    if (r == 5'd0)                 return 64'd0;
    else if (x_wr && x_rt == r)    return x_res;
    else if (m_wr && m_rt == r)    return m_res;
    else if (w_wr && w_rt == r)    return w_res;
    else                           return rf_data;
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    a_sel   = '0;
    b_sel   = '0;
    imm_sel = '0;
    a_sel = forward(ra, bus.rfoa,
                    bus.xRt, bus.xres, bus.xwr,
                    bus.mRt, bus.mres, bus.mwr,
                    bus.wRt, bus.wres, bus.wwr);
    if (is_rr) begin
      b_sel = forward(rb, bus.rfob,
                      bus.xRt, bus.xres, bus.xwr,
                      bus.mRt, bus.mres, bus.mwr,
                      bus.wRt, bus.wres, bus.wwr);
    end else begin
      imm_sel = {{39{bus.rIR[24]}}, bus.rIR[24:0]};
    end
  end

  // A load in x has no result yet, so a consumer must wait one cycle for it to reach m.
  assign hazard = bus.rvalid & x_valid & bus.xLoad & (bus.xRt != 5'd0) &
                  ((bus.xRt == ra) | (is_rr & (bus.xRt == rb)));

  assign bus.rstall = bus.xstall | (hazard & ~bus.flush);

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      x_ir        <= '0;
      x_valid     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      ilock_cnt_q <= '0;
    end else if (bus.flush) begin
      x_ir    <= '0;
      x_valid <= 1'b0;
    end else if (bus.xstall) begin
      x_ir    <= x_ir;
      x_valid <= x_valid;
    end else if (hazard) begin
      x_ir    <= '0;
      x_valid <= 1'b0;
      if (ilock_cnt_q != 32'hFFFF_FFFF) ilock_cnt_q <= ilock_cnt_q + 32'd1;
    end else begin
      x_ir    <= bus.rIR;
      x_valid <= bus.rvalid;
      a_q     <= a_sel;
      b_q     <= b_sel;
      imm_q   <= imm_sel;
    end
  end

  assign bus.xIR       = x_ir;
  assign bus.xvalid    = x_valid;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.imm       = imm_q;
  assign bus.ilock_cnt = ilock_cnt_q;

endmodule
